// File: rtl/scarv_cop_issue_pkg.sv
// Shared XCrypto coprocessor types: issue FSM encoding, request payload and
// response record, plus the datapath width constants.
package scarv_cop_issue_pkg;

  localparam int SCARV_COP_ENC_W = 32;
  localparam int SCARV_COP_GPR_W = 32;
  localparam int SCARV_COP_RD_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_RESP
  } issue_state_t;

  typedef struct packed {
    logic [SCARV_COP_ENC_W-1:0] enc;
    logic [SCARV_COP_GPR_W-1:0] rs1;
    logic [SCARV_COP_GPR_W-1:0] rs2;
  } req_t;

  typedef struct packed {
    logic                       ex;
    logic                       wen;
    logic [SCARV_COP_RD_W-1:0]  rd;
    logic [SCARV_COP_GPR_W-1:0] wdata;
  } rsp_t;

  localparam int   SCARV_COP_REQ_W       = $bits(req_t);
  localparam rsp_t SCARV_COP_RSP_ILLEGAL = '{ex: 1'b1, wen: 1'b0, rd: '0, wdata: '0};

endpackage

// File: rtl/scarv_cop_issue_if.sv
// Host request/response, decoder and execute signals of the issue stage.
// slave = the issue stage itself; master = the surrounding host/decoder/execute.
interface scarv_cop_issue_if;
  import scarv_cop_issue_pkg::*;

  logic                       cpu_req_valid;
  logic                       cpu_req_ready;
  logic [SCARV_COP_ENC_W-1:0] cpu_req_enc;
  logic [SCARV_COP_GPR_W-1:0] cpu_req_rs1;
  logic [SCARV_COP_GPR_W-1:0] cpu_req_rs2;
  logic                       cpu_rsp_valid;
  logic                       cpu_rsp_ready;
  logic                       cpu_rsp_ex;
  logic                       cpu_rsp_wen;
  logic [SCARV_COP_RD_W-1:0]  cpu_rsp_rd;
  logic [SCARV_COP_GPR_W-1:0] cpu_rsp_wdata;
  logic [SCARV_COP_ENC_W-1:0] id_encoded;
  logic                       id_exception;
  logic                       ex_valid;
  logic                       ex_ready;
  logic [SCARV_COP_GPR_W-1:0] ex_rs1;
  logic [SCARV_COP_GPR_W-1:0] ex_rs2;
  logic                       ex_done;
  logic                       ex_wen;
  logic [SCARV_COP_RD_W-1:0]  ex_rd;
  logic [SCARV_COP_GPR_W-1:0] ex_wdata;

  modport slave (
    input  cpu_req_valid, cpu_req_enc, cpu_req_rs1, cpu_req_rs2, cpu_rsp_ready,
           id_exception, ex_ready, ex_done, ex_wen, ex_rd, ex_wdata,
    output cpu_req_ready, cpu_rsp_valid, cpu_rsp_ex, cpu_rsp_wen, cpu_rsp_rd,
           cpu_rsp_wdata, id_encoded, ex_valid, ex_rs1, ex_rs2
  );

  modport master (
    output cpu_req_valid, cpu_req_enc, cpu_req_rs1, cpu_req_rs2, cpu_rsp_ready,
           id_exception, ex_ready, ex_done, ex_wen, ex_rd, ex_wdata,
    input  cpu_req_ready, cpu_rsp_valid, cpu_rsp_ex, cpu_rsp_wen, cpu_rsp_rd,
           cpu_rsp_wdata, id_encoded, ex_valid, ex_rs1, ex_rs2
  );

endinterface

// File: rtl/scarv_cop_req_fifo.sv
// Request FIFO, DEPTH entries of W bits; head is the raw entry at the read pointer.
// Push is refused when full (no same-cycle bypass); pop is ignored when empty.
module scarv_cop_req_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 96
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];

  // Storage needs no reset: the consumer masks the head while empty.
  always_ff @(posedge g_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/scarv_cop_issue.sv
// XCrypto issue stage: buffers host requests, dispatches the head or flags it illegal,
// and returns one in-order response; head stays in the FIFO until its response is taken.
module scarv_cop_issue
  import scarv_cop_issue_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input logic              g_clk,
  input logic              g_resetn,
  scarv_cop_issue_if.slave bus
);

  issue_state_t r_state;
  issue_state_t w_state_nxt;
  rsp_t         r_rsp;
  rsp_t         w_rsp_nxt;
  req_t         w_push_dat;
  req_t         w_head_raw;
  req_t         w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_pop;

  assign w_push_dat = '{enc: bus.cpu_req_enc, rs1: bus.cpu_req_rs1, rs2: bus.cpu_req_rs2};

  scarv_cop_req_fifo #(
    .DEPTH (DEPTH),
    .W     (SCARV_COP_REQ_W)
  ) u_fifo (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .i_push   (bus.cpu_req_valid),
    .i_pop    (w_pop),
    .i_data   (w_push_dat),
    .o_full   (w_full),
    .o_empty  (w_empty),
    .o_head   (w_head_raw)
  );

  // Stale storage must never leak to the decoder or execute operands.
  assign w_head = w_empty ? '0 : w_head_raw;

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      r_state <= ST_IDLE;
      r_rsp   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rsp   <= w_rsp_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rsp_nxt   = r_rsp;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          if (bus.id_exception) begin
            w_rsp_nxt   = SCARV_COP_RSP_ILLEGAL;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_DISPATCH;
          end
        end
      end
      ST_DISPATCH: begin
        if (bus.ex_ready) w_state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.ex_done) begin
          w_rsp_nxt   = '{ex: 1'b0, wen: bus.ex_wen, rd: bus.ex_rd, wdata: bus.ex_wdata};
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.cpu_rsp_ready) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.cpu_req_ready = !w_full;
  assign bus.cpu_rsp_valid = (r_state == ST_RESP);
  assign bus.cpu_rsp_ex    = r_rsp.ex;
  assign bus.cpu_rsp_wen   = r_rsp.wen;
  assign bus.cpu_rsp_rd    = r_rsp.rd;
  assign bus.cpu_rsp_wdata = r_rsp.wdata;
  assign bus.ex_valid      = (r_state == ST_DISPATCH);
  assign bus.id_encoded    = w_head.enc;
  assign bus.ex_rs1        = w_head.rs1;
  assign bus.ex_rs2        = w_head.rs2;

endmodule

// File: tb/tb_scarv_cop_issue.sv
// Directed bench for scarv_cop_issue: legal, illegal, full/backpressure,
// response stall, pointer wrap and mid-operation reset.
module tb_scarv_cop_issue;

  logic g_clk;
  logic g_resetn;
  int   checks;
  int   failures;

  scarv_cop_issue_if u_if ();

  scarv_cop_issue #(.DEPTH(2)) u_dut (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .bus      (u_if)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge g_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: got %h, required %h", tag, obs, exp);
    end
  endtask

  // Runs one legal head instruction through dispatch, execute and response.
  task automatic exec_one(input logic [31:0] enc, input logic [31:0] rs1,
                          input logic [31:0] rs2, input logic wen, input logic [4:0] rd,
                          input logic [31:0] wd, input int lat, input int stall);
    int n;
    n = 0;
    u_if.ex_ready = 1'b1;
    while (!u_if.ex_valid && n < 8) begin
      tick();
      n++;
    end
    chk("disp_seen", u_if.ex_valid, 1);
    chk("disp_enc", u_if.id_encoded, enc);
    chk("disp_rs1", u_if.ex_rs1, rs1);
    chk("disp_rs2", u_if.ex_rs2, rs2);
    tick();
    u_if.ex_ready = 1'b0;
    chk("wait_exv", u_if.ex_valid, 0);
    repeat (lat) tick();
    u_if.ex_done  = 1'b1;
    u_if.ex_wen   = wen;
    u_if.ex_rd    = rd;
    u_if.ex_wdata = wd;
    tick();
    u_if.ex_done = 1'b0;
    chk("rsp_vld", u_if.cpu_rsp_valid, 1);
    chk("rsp_ex", u_if.cpu_rsp_ex, 0);
    chk("rsp_wen", u_if.cpu_rsp_wen, wen);
    chk("rsp_rd", u_if.cpu_rsp_rd, rd);
    chk("rsp_wdata", u_if.cpu_rsp_wdata, wd);
    for (int s = 0; s < stall; s++) begin
      tick();
      chk("stall_vld", u_if.cpu_rsp_valid, 1);
      chk("stall_wdata", u_if.cpu_rsp_wdata, wd);
      chk("stall_head", u_if.id_encoded, enc);
    end
    u_if.cpu_rsp_ready = 1'b1;
    tick();
    u_if.cpu_rsp_ready = 1'b0;
    chk("rsp_drop", u_if.cpu_rsp_valid, 0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    g_resetn = 1'b0;
    u_if.cpu_req_valid = 1'b0;
    u_if.cpu_req_enc   = '0;
    u_if.cpu_req_rs1   = '0;
    u_if.cpu_req_rs2   = '0;
    u_if.cpu_rsp_ready = 1'b0;
    u_if.id_exception  = 1'b0;
    u_if.ex_ready      = 1'b0;
    u_if.ex_done       = 1'b0;
    u_if.ex_wen        = 1'b0;
    u_if.ex_rd         = '0;
    u_if.ex_wdata      = '0;
    tick();
    tick();
    g_resetn = 1'b1;
    tick();

    chk("rst_req_rdy", u_if.cpu_req_ready, 1);
    chk("rst_rsp_vld", u_if.cpu_rsp_valid, 0);
    chk("rst_id_enc", u_if.id_encoded, 0);
    chk("rst_ex_vld", u_if.ex_valid, 0);
    chk("rst_rsp_wdata", u_if.cpu_rsp_wdata, 0);

    // Single legal instruction with exact cycle timing.
    u_if.cpu_req_valid = 1'b1;
    u_if.cpu_req_enc   = 32'h0000_802B;
    u_if.cpu_req_rs1   = 32'h11;
    u_if.cpu_req_rs2   = 32'h22;
    tick();
    u_if.cpu_req_valid = 1'b0;
    chk("l_n1_enc", u_if.id_encoded, 32'h0000_802B);
    chk("l_n1_exv", u_if.ex_valid, 0);
    tick();
    chk("l_n2_exv", u_if.ex_valid, 1);
    chk("l_n2_rs1", u_if.ex_rs1, 32'h11);
    chk("l_n2_rs2", u_if.ex_rs2, 32'h22);
    u_if.ex_ready = 1'b1;
    tick();
    u_if.ex_ready = 1'b0;
    chk("l_n3_exv", u_if.ex_valid, 0);
    chk("l_n3_rspv", u_if.cpu_rsp_valid, 0);
    u_if.ex_done  = 1'b1;
    u_if.ex_wen   = 1'b1;
    u_if.ex_rd    = 5'd5;
    u_if.ex_wdata = 32'hDEAD_BEEF;
    tick();
    u_if.ex_done = 1'b0;
    chk("l_n4_rspv", u_if.cpu_rsp_valid, 1);
    chk("l_n4_ex", u_if.cpu_rsp_ex, 0);
    chk("l_n4_wen", u_if.cpu_rsp_wen, 1);
    chk("l_n4_rd", u_if.cpu_rsp_rd, 5);
    chk("l_n4_wdata", u_if.cpu_rsp_wdata, 32'hDEAD_BEEF);
    u_if.cpu_rsp_ready = 1'b1;
    tick();
    u_if.cpu_rsp_ready = 1'b0;
    chk("l_n5_rspv", u_if.cpu_rsp_valid, 0);
    chk("l_n5_enc", u_if.id_encoded, 0);

    // Illegal instruction: answered at N+2, never dispatched.
    u_if.cpu_req_valid = 1'b1;
    u_if.cpu_req_enc   = 32'hFFFF_FFFF;
    u_if.cpu_req_rs1   = 32'h1;
    u_if.cpu_req_rs2   = 32'h2;
    u_if.id_exception  = 1'b1;
    tick();
    u_if.cpu_req_valid = 1'b0;
    chk("i_n1_exv", u_if.ex_valid, 0);
    chk("i_n1_enc", u_if.id_encoded, 32'hFFFF_FFFF);
    tick();
    chk("i_n2_rspv", u_if.cpu_rsp_valid, 1);
    chk("i_n2_ex", u_if.cpu_rsp_ex, 1);
    chk("i_n2_wen", u_if.cpu_rsp_wen, 0);
    chk("i_n2_rd", u_if.cpu_rsp_rd, 0);
    chk("i_n2_wdata", u_if.cpu_rsp_wdata, 0);
    chk("i_n2_exv", u_if.ex_valid, 0);
    u_if.id_exception  = 1'b0;
    u_if.cpu_rsp_ready = 1'b1;
    tick();
    u_if.cpu_rsp_ready = 1'b0;
    chk("i_n3_rspv", u_if.cpu_rsp_valid, 0);
    chk("i_n3_exv", u_if.ex_valid, 0);
    chk("i_n3_enc", u_if.id_encoded, 0);

    // Back-pressure: fill with execute stalled, third request held off.
    u_if.cpu_req_valid = 1'b1;
    u_if.cpu_req_enc   = 32'hA000_0001;
    u_if.cpu_req_rs1   = 32'hA11;
    u_if.cpu_req_rs2   = 32'hA22;
    tick();
    chk("f_rdy_one", u_if.cpu_req_ready, 1);
    u_if.cpu_req_enc   = 32'hB000_0002;
    u_if.cpu_req_rs1   = 32'hB11;
    u_if.cpu_req_rs2   = 32'hB22;
    tick();
    chk("f_rdy_full", u_if.cpu_req_ready, 0);
    chk("f_exv", u_if.ex_valid, 1);
    chk("f_head", u_if.id_encoded, 32'hA000_0001);
    u_if.cpu_req_enc   = 32'hC000_0003;
    u_if.cpu_req_rs1   = 32'hC11;
    u_if.cpu_req_rs2   = 32'hC22;
    repeat (3) tick();
    chk("f_held_rdy", u_if.cpu_req_ready, 0);
    chk("f_held_exv", u_if.ex_valid, 1);
    chk("f_held_head", u_if.id_encoded, 32'hA000_0001);
    exec_one(32'hA000_0001, 32'hA11, 32'hA22, 1'b1, 5'd1, 32'h0000_AAAA, 0, 0);
    chk("f_rdy_rise", u_if.cpu_req_ready, 1);
    chk("f_head_b", u_if.id_encoded, 32'hB000_0002);
    tick();
    u_if.cpu_req_valid = 1'b0;
    chk("f_rdy_refull", u_if.cpu_req_ready, 0);
    exec_one(32'hB000_0002, 32'hB11, 32'hB22, 1'b0, 5'd2, 32'h0000_BBBB, 1, 0);
    exec_one(32'hC000_0003, 32'hC11, 32'hC22, 1'b1, 5'd3, 32'h0000_CCCC, 2, 0);
    chk("f_empty", u_if.id_encoded, 0);

    // Response stall with a concurrent push.
    u_if.cpu_req_valid = 1'b1;
    u_if.cpu_req_enc   = 32'hD000_0004;
    u_if.cpu_req_rs1   = 32'hD11;
    u_if.cpu_req_rs2   = 32'hD22;
    tick();
    u_if.cpu_req_valid = 1'b0;
    fork
      exec_one(32'hD000_0004, 32'hD11, 32'hD22, 1'b1, 5'd4, 32'h0000_DDDD, 1, 10);
      begin
        repeat (5) tick();
        u_if.cpu_req_valid = 1'b1;
        u_if.cpu_req_enc   = 32'hE000_0005;
        u_if.cpu_req_rs1   = 32'hE11;
        u_if.cpu_req_rs2   = 32'hE22;
        chk("s_push_rdy", u_if.cpu_req_ready, 1);
        tick();
        u_if.cpu_req_valid = 1'b0;
      end
    join
    chk("s_head_e", u_if.id_encoded, 32'hE000_0005);
    exec_one(32'hE000_0005, 32'hE11, 32'hE22, 1'b0, 5'd6, 32'h0000_EEEE, 0, 0);

    // Nine back-to-back instructions across pointer wrap.
    fork
      begin
        for (int i = 0; i < 9; i++) begin
          int  n;
          logic rdy;
          u_if.cpu_req_valid = 1'b1;
          u_if.cpu_req_enc   = 32'h0100_0000 + 32'(i);
          u_if.cpu_req_rs1   = 32'h0000_0100 + 32'(i);
          u_if.cpu_req_rs2   = 32'h0000_0200 + 32'(i);
          n = 0;
          do begin
            rdy = u_if.cpu_req_ready;
            tick();
            n++;
          end while (!rdy && n < 40);
          chk("w_push_ok", rdy, 1);
        end
        u_if.cpu_req_valid = 1'b0;
      end
      begin
        for (int j = 0; j < 9; j++) begin
          exec_one(32'h0100_0000 + 32'(j), 32'h0000_0100 + 32'(j), 32'h0000_0200 + 32'(j),
                   j[0], 5'(j + 1), 32'hC0DE_0000 + 32'(j), int'($urandom_range(3, 0)), 0);
        end
      end
    join
    chk("w_end_enc", u_if.id_encoded, 0);
    chk("w_end_rdy", u_if.cpu_req_ready, 1);
    chk("w_end_rspv", u_if.cpu_rsp_valid, 0);

    // Reset asserted mid-WAIT with the FIFO full.
    u_if.cpu_req_valid = 1'b1;
    u_if.cpu_req_enc   = 32'hF000_0006;
    u_if.cpu_req_rs1   = 32'hF11;
    u_if.cpu_req_rs2   = 32'hF22;
    tick();
    u_if.cpu_req_enc   = 32'h6000_0007;
    tick();
    u_if.cpu_req_valid = 1'b0;
    chk("r_disp", u_if.ex_valid, 1);
    u_if.ex_ready = 1'b1;
    tick();
    u_if.ex_ready = 1'b0;
    chk("r_wait_exv", u_if.ex_valid, 0);
    chk("r_wait_full", u_if.cpu_req_ready, 0);
    #2;
    g_resetn = 1'b0;
    #1;
    chk("r_async_rdy", u_if.cpu_req_ready, 1);
    chk("r_async_rspv", u_if.cpu_rsp_valid, 0);
    chk("r_async_exv", u_if.ex_valid, 0);
    chk("r_async_enc", u_if.id_encoded, 0);
    chk("r_async_rs1", u_if.ex_rs1, 0);
    chk("r_async_rs2", u_if.ex_rs2, 0);
    chk("r_async_wen", u_if.cpu_rsp_wen, 0);
    chk("r_async_rd", u_if.cpu_rsp_rd, 0);
    chk("r_async_wdata", u_if.cpu_rsp_wdata, 0);
    tick();
    g_resetn = 1'b1;
    u_if.ex_done  = 1'b0;
    u_if.cpu_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("r_post_rspv", u_if.cpu_rsp_valid, 0);
      chk("r_post_exv", u_if.ex_valid, 0);
      chk("r_post_enc", u_if.id_encoded, 0);
    end
    u_if.cpu_rsp_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scarv_cop_issue.md
# scarv_cop_issue

Instruction issue stage for the XCrypto coprocessor, sitting between the host core's coprocessor request port and the combinational instruction decoder. It buffers host requests (encoding plus GPR operands) in a small FIFO and presents the head encoding to the decoder. It then either dispatches the instruction to the execute stage or answers it immediately as illegal. Finally it returns one ordered response per instruction to the host.

## Interface
Parameters:
- DEPTH, 2, request FIFO entries; power of two, ≥2
- Derived: PTR_W = log2(DEPTH)

Ports:
- Clock and reset: one clock, g_clk; reset g_resetn is asynchronous, active-low.
- g_clk  in  1  clock
- g_resetn  in  1  asynchronous active-low reset
- cpu_req_valid  in  1  host request valid
- cpu_req_ready  out  1  request FIFO can accept
- cpu_req_enc  in  32  instruction encoding
- cpu_req_rs1  in  32  GPR rs1 value
- cpu_req_rs2  in  32  GPR rs2 value
- cpu_rsp_valid  out  1  response valid
- cpu_rsp_ready  in  1  host accepts response
- cpu_rsp_ex  out  1  illegal-instruction exception
- cpu_rsp_wen  out  1  write GPR rd
- cpu_rsp_rd  out  5  GPR destination
- cpu_rsp_wdata  out  32  GPR write data
- id_encoded  out  32  head encoding to decoder (0 when FIFO empty)
- id_exception  in  1  decoder illegal flag for id_encoded
- ex_valid  out  1  dispatch head to execute
- ex_ready  in  1  execute accepts dispatch
- ex_rs1  out  32  head rs1 value
- ex_rs2  out  32  head rs2 value
- ex_done  in  1  execute finished head instruction
- ex_wen  in  1  result writes GPR
- ex_rd  in  5  result GPR index
- ex_wdata  in  32  result data

## Operation
- FIFO storage:
  - Each entry holds {enc, rs1, rs2}.
  - Push on cpu_req_valid && cpu_req_ready.
  - cpu_req_ready = (count != DEPTH). There is no bypass, so a full FIFO refuses a push even in a pop cycle.
  - Pointers wrap modulo DEPTH. count is PTR_W+1 bits.
- The head entry stays at the FIFO output until its response is accepted. id_encoded, ex_rs1 and ex_rs2 are stable through dispatch and execution.
- FSM states: IDLE, DISPATCH, WAIT, RESP.
  - IDLE:
    - FIFO empty → stay.
    - Head present and id_exception=1 → load rsp {ex=1, wen=0, rd=0, wdata=0}, go to RESP.
    - Otherwise → DISPATCH.
  - DISPATCH: ex_valid=1. On ex_ready → WAIT. ex_valid must not drop before ex_ready.
  - WAIT: on ex_done → capture {ex=0, ex_wen, ex_rd, ex_wdata} into the response registers, go to RESP.
  - RESP: cpu_rsp_valid=1 with stable payload. On cpu_rsp_ready → pop head, go to IDLE.
- Ordering: exactly one response per accepted request, in request order. At most one instruction is in execute.
- Ignored inputs:
  - ex_done outside WAIT is ignored (bench asserts it never occurs).
  - ex_ready outside DISPATCH is ignored.
- A push while in any state is independent of the FSM.
- A simultaneous push and pop with count<DEPTH leaves count unchanged and advances both pointers.

## Timing
- Reset values:
  - state=IDLE, count=0, pointers=0.
  - cpu_req_ready=1, cpu_rsp_valid=0, cpu_rsp_ex=0, cpu_rsp_wen=0, cpu_rsp_rd=0, cpu_rsp_wdata=0.
  - ex_valid=0, id_encoded=0, ex_rs1=0, ex_rs2=0.
- Reset asserted mid-operation discards all FIFO contents, any in-flight dispatch and any pending response. No response is produced for those instructions.
- Outputs are registered or derived from FSM state, FIFO head and count only. There is no combinational path from cpu_req_valid to any output, and none from cpu_rsp_ready or ex_ready to ex_valid or cpu_rsp_valid.
- Legal instruction, zero-wait execute, request accepted at cycle N:
  - Head and id_encoded visible at N+1 (IDLE).
  - DISPATCH at N+2; ex_ready at N+2 → WAIT at N+3.
  - ex_done at N+3 → RESP with cpu_rsp_valid at N+4.
  - Accepted at N+4 → IDLE at N+5. Minimum 5-cycle occupancy.
- Illegal instruction accepted at N: cpu_rsp_valid=1, cpu_rsp_ex=1 at N+2.
- id_exception is sampled only in IDLE with the FIFO non-empty.

## Structure
- The FSM state encoding and the response-record struct {ex, wen, rd[4:0], wdata[31:0]} belong in the shared coprocessor package, alongside the SCARV_COP_* constants.
- The FIFO is one natural sub-module, scarv_cop_req_fifo, parameterised by DEPTH and a 96-bit payload. It exposes push, pop, full, empty and head. The FSM and response registers stay in scarv_cop_issue.

## Test plan
- Reset then idle: after g_resetn release, cpu_req_ready=1, cpu_rsp_valid=0 and id_encoded=0; assert g_resetn low mid-WAIT → all outputs return to reset values within the same cycle.
- Single legal instruction:
  - Stimulus: push enc=0x0000_802B, rs1=0x11, rs2=0x22. Execute returns ex_done with wen=1, rd=5, wdata=0xDEAD_BEEF.
  - Required: ex_rs1=0x11 and ex_rs2=0x22 during DISPATCH; response {ex=0, wen=1, rd=5, wdata=0xDEAD_BEEF} at N+4.
- Illegal instruction: push with id_exception forced 1 → response {ex=1, wen=0, rd=0} at N+2; ex_valid never asserted.
- Back-pressure and full:
  - Stimulus: hold ex_ready=0 and push 3 requests with DEPTH=2.
  - Required: cpu_req_ready=0 after the second push, and the third is held off. Release ex_ready and cpu_rsp_ready → three responses in push order. cpu_req_ready rises the cycle after the first pop.
- Response stall: hold cpu_rsp_ready=0 for 10 cycles in RESP → payload stable and no pop. Meanwhile a push still succeeds while count<DEPTH.
- Wrap-around: 9 back-to-back legal instructions with random execute latency 0–3 → 9 in-order responses; pointers wrap correctly and count returns to 0.
